// File: rtl/dcsa_fault_monitor.sv
// Fault monitor for the duplicated carry-select adder: registers the sum pair and
// parity signals, checks them, counts faults, logs the first fault and raises alarms.
module dcsa_fault_monitor #(
  parameter int WIDTH       = 64,
  parameter int INV_DUP     = 1,
  parameter int CNT_W       = 8,
  parameter int LOCK_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] s_invert,
  input  logic             papb,
  input  logic             pab,
  input  logic             clear_req,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_out,
  output logic             dup_err,
  output logic             par_err,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [WIDTH-1:0] first_syndrome,
  output logic [1:0]       first_type,
  output logic             alarm,
  output logic             locked,
  output logic             clear_ack
);

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FAULT  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [WIDTH-1:0] INV_MASK = (INV_DUP != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(LOCK_THRESH);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_s;
  logic [WIDTH-1:0] r_s1_sinv;
  logic             r_s1_papb;
  logic             r_s1_pab;

  logic [1:0]       r_state;
  logic             r_clr_armed;

  logic [WIDTH-1:0] w_syndrome;
  logic             w_dup;
  logic             w_par;
  logic             w_faulty;
  logic             w_clr_acc;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_lock_hit;

  // Stage 1: capture adder outputs; data only loads on a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_s     <= '0;
      r_s1_sinv  <= '0;
      r_s1_papb  <= 1'b0;
      r_s1_pab   <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_s    <= s;
        r_s1_sinv <= s_invert;
        r_s1_papb <= papb;
        r_s1_pab  <= pab;
      end
    end
  end

  always_comb begin
    w_syndrome = r_s1_s ^ r_s1_sinv ^ INV_MASK;
    w_dup      = |w_syndrome;
    w_par      = r_s1_papb ^ r_s1_pab;
    w_faulty   = r_s1_valid & (w_dup | w_par);
    w_clr_acc  = clear_req & r_clr_armed;
    w_cnt_inc  = (fault_cnt == CNT_MAX) ? fault_cnt : fault_cnt + CNT_W'(1);
    w_lock_hit = (w_cnt_inc >= THRESH);
  end

  // Stage 2: registered check results; sum_out holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_out   <= '0;
      dup_err   <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      dup_err   <= r_s1_valid & w_dup;
      par_err   <= r_s1_valid & w_par;
      if (r_s1_valid) begin
        sum_out <= r_s1_s;
      end
    end
  end

  // A clear is accepted only after clear_req was low; it overrides a coincident fault
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_OK;
      r_clr_armed    <= 1'b1;
      clear_ack      <= 1'b0;
      fault_cnt      <= '0;
      first_syndrome <= '0;
      first_type     <= '0;
    end else begin
      r_clr_armed <= ~clear_req;
      clear_ack   <= w_clr_acc;
      if (w_clr_acc) begin
        r_state        <= ST_OK;
        fault_cnt      <= '0;
        first_syndrome <= '0;
        first_type     <= '0;
      end else if (w_faulty) begin
        fault_cnt <= w_cnt_inc;
        if (r_state == ST_OK) begin
          first_syndrome <= w_syndrome;
          first_type     <= {w_dup, w_par};
        end
        if (w_lock_hit) begin
          r_state <= ST_LOCKED;
        end else if (r_state == ST_OK) begin
          r_state <= ST_FAULT;
        end
      end
    end
  end

  assign alarm  = (r_state == ST_FAULT) || (r_state == ST_LOCKED);
  assign locked = (r_state == ST_LOCKED);

endmodule
